// File: rtl/alu_exec_ctrl.sv
// Execution sequencer around a combinational ALU: reads operands from a small
// register file, drives the ALU for one cycle, writes back and hands off the result.
module alu_exec_ctrl #(
  parameter  int NREG = 8,
  parameter  int DW   = 32,
  parameter  int CNTW = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [3:0]      instr_op,
  input  logic [AW-1:0]   instr_rd,
  input  logic [AW-1:0]   instr_rs1,
  input  logic [AW-1:0]   instr_rs2,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_data,
  output logic [3:0]      alu_sel,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_over,
  input  logic            alu_under,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic [AW-1:0]   res_rd,
  output logic            res_over,
  output logic            res_under,
  output logic            res_err,
  output logic            sticky_over,
  output logic            sticky_under,
  input  logic            flag_clr,
  output logic [CNTW-1:0] instr_count
);

  // Opcodes 0..OP_LAST are defined by the ALU; anything above is reported as an error.
  localparam logic [3:0] OP_LAST = 4'd11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic [NREG-1:0][DW-1:0] rf;

  logic accept, ld_fire, in_exec, op_undef, wb_en, set_over, set_under;

  assign accept    = (state == IDLE) && instr_valid;
  assign ld_fire   = ld_valid && ld_ready;
  assign in_exec   = (state == EXEC);
  assign op_undef  = (alu_sel > OP_LAST);
  assign wb_en     = in_exec && !op_undef;
  assign set_over  = wb_en && alu_over;
  assign set_under = wb_en && alu_under;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    ld_ready    = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        ld_ready    = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        ld_ready  = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf           <= '0;
      alu_sel      <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      res_data     <= '0;
      res_rd       <= '0;
      res_over     <= 1'b0;
      res_under    <= 1'b0;
      res_err      <= 1'b0;
      sticky_over  <= 1'b0;
      sticky_under <= 1'b0;
      instr_count  <= '0;
    end else begin
      // rf[0] is never written, so reading it directly always yields zero.
      if (accept) begin
        alu_sel <= instr_op;
        alu_a   <= rf[instr_rs1];
        alu_b   <= rf[instr_rs2];
        res_rd  <= instr_rd;
      end
      if (in_exec) begin
        res_data  <= alu_out;
        res_over  <= set_over;
        res_under <= set_under;
        res_err   <= op_undef;
      end
      // Loads are blocked during EXEC, so writeback and load never meet.
      for (int i = 1; i < NREG; i++) begin
        if (wb_en && res_rd == AW'(i))
          rf[i] <= alu_out;
        else if (ld_fire && ld_addr == AW'(i))
          rf[i] <= ld_data;
      end
      sticky_over  <= (sticky_over  && !flag_clr) || set_over;
      sticky_under <= (sticky_under && !flag_clr) || set_under;
      if (res_valid && res_ready) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU, shadow register file and a
// result scoreboard checked at every result handshake.
module tb_alu_exec_ctrl;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, AND_ = 4'd3, OR_ = 4'd4,
                         XOR_ = 4'd5, NOT_ = 4'd6, EQ = 4'd7, GT = 4'd8, GTE = 4'd9,
                         LT = 4'd10, LTE = 4'd11, BAD = 4'd13;

  logic clk = 0, rst_n = 0;
  logic instr_valid = 0, instr_ready;
  logic [3:0] instr_op = 0;
  logic [2:0] instr_rd = 0, instr_rs1 = 0, instr_rs2 = 0;
  logic ld_valid = 0, ld_ready;
  logic [2:0] ld_addr = 0;
  logic [31:0] ld_data = 0;
  logic [3:0] alu_sel;
  logic [31:0] alu_a, alu_b, alu_out;
  logic alu_over, alu_under;
  logic res_valid, res_ready = 1;
  logic [31:0] res_data;
  logic [2:0] res_rd;
  logic res_over, res_under, res_err, sticky_over, sticky_under;
  logic flag_clr = 0;
  logic [15:0] instr_count;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_over(alu_over), .alu_under(alu_under),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .res_over(res_over), .res_under(res_under), .res_err(res_err),
    .sticky_over(sticky_over), .sticky_under(sticky_under), .flag_clr(flag_clr),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Signed-arithmetic ALU; undefined opcodes return ~a with both flags raised.
  function automatic logic [33:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] o;
    logic ov, un;
    logic signed [63:0] sa, sb, p;
    o = '0; ov = 0; un = 0;
    sa = $signed(a); sb = $signed(b); p = sa * sb;
    case (op)
      ADD:  begin o = a + b; ov = !a[31] && !b[31] && o[31]; un = a[31] && b[31] && !o[31]; end
      SUB:  begin o = a - b; ov = !a[31] && b[31] && o[31]; un = a[31] && !b[31] && !o[31]; end
      MUL:  begin o = p[31:0]; ov = p > 64'sd2147483647; un = p < -64'sd2147483648; end
      AND_: o = a & b;
      OR_:  o = a | b;
      XOR_: o = a ^ b;
      NOT_: o = ~a;
      EQ:   o = {31'b0, a == b};
      GT:   o = {31'b0, $signed(a) >  $signed(b)};
      GTE:  o = {31'b0, $signed(a) >= $signed(b)};
      LT:   o = {31'b0, $signed(a) <  $signed(b)};
      LTE:  o = {31'b0, $signed(a) <= $signed(b)};
      default: begin o = ~a; ov = 1; un = 1; end
    endcase
    return {o, ov, un};
  endfunction

  always_comb {alu_out, alu_over, alu_under} = alu_f(alu_sel, alu_a, alu_b);

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  rd;
    logic ov, un, err;
  } exp_t;

  exp_t sb[$];
  logic [31:0] sh [8];
  logic [15:0] exp_cnt = 0;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Push the expected result of an instruction; optional same-cycle load lands first.
  task automatic expect_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                              input logic [2:0] rs2, input bit ld_en, input logic [2:0] la,
                              input logic [31:0] ld);
    logic [33:0] r;
    exp_t e;
    bit err;
    r   = alu_f(op, sh[rs1], sh[rs2]);
    err = op > LTE;
    e.d = r[33:2]; e.rd = rd; e.ov = !err && r[1]; e.un = !err && r[0]; e.err = err;
    sb.push_back(e);
    exp_cnt++;
    if (ld_en && la != 0) sh[la] = ld;
    if (!err && rd != 0) sh[rd] = r[33:2];
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data",  res_data,  e.d);
        chk("res_rd",    res_rd,    e.rd);
        chk("res_over",  res_over,  e.ov);
        chk("res_under", res_under, e.un);
        chk("res_err",   res_err,   e.err);
      end
    end
  end

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (instr_ready && !res_valid) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ld_valid = 1; ld_addr = a; ld_data = d;
    @(negedge clk);
    chk("ld_ready_idle", ld_ready, 1);
    @(posedge clk); #1;
    ld_valid = 0;
    if (a != 0) sh[a] = d;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input bit ld_en = 0, input logic [2:0] la = 0,
                       input logic [31:0] ld = 0, input bit clr = 0, input bit wait_done = 1);
    @(posedge clk); #1;
    instr_valid = 1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    if (ld_en) begin ld_valid = 1; ld_addr = la; ld_data = ld; end
    expect_instr(op, rd, rs1, rs2, ld_en, la, ld);
    @(negedge clk);
    chk("instr_ready_idle", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 0; ld_valid = 0;
    if (clr) flag_clr = 1;
    @(negedge clk);
    chk("exec_res_valid", res_valid, 0);
    chk("exec_ld_ready", ld_ready, 0);
    chk("exec_instr_ready", instr_ready, 0);
    @(posedge clk); #1;
    flag_clr = 0;
    @(negedge clk);
    chk("res_valid_latency", res_valid, 1);
    if (wait_done) wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) sh[i] = '0;
    #12;
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_sticky", {sticky_over, sticky_under}, 0);
    chk("rst_alu", {alu_sel, alu_a, alu_b}, 0);
    rst_n = 1;

    // Basic ADD, latency and writeback
    load(1, 1); load(2, 2);
    issue(ADD, 3, 1, 2, .wait_done(0));
    chk("add_res_data", res_data, 3);
    wait_idle();
    chk("count_1", instr_count, 1);
    issue(ADD, 7, 3, 0);
    load(0, 5);
    issue(ADD, 7, 0, 0);

    // Overflow, sticky hold, clear, set-wins-over-clear, underflow
    load(1, 32'h7FFF_FFFF); load(2, 1);
    issue(ADD, 4, 1, 2);
    chk("sticky_over_set", sticky_over, 1);
    issue(SUB, 0, 0, 0);
    chk("sticky_over_hold", sticky_over, 1);
    @(posedge clk); #1; flag_clr = 1;
    @(posedge clk); #1; flag_clr = 0;
    @(negedge clk);
    chk("sticky_over_clr", sticky_over, 0);
    issue(ADD, 4, 1, 2, .clr(1));
    chk("sticky_set_wins", sticky_over, 1);
    load(3, 32'h8000_0000);
    issue(SUB, 5, 3, 2);
    chk("sticky_under_set", sticky_under, 1);

    // Backpressure on a MUL; a pending instruction waits for IDLE
    load(1, 3); load(2, 7);
    res_ready = 0;
    issue(MUL, 5, 1, 2, .wait_done(0));
    instr_valid = 1; instr_op = ADD; instr_rd = 6; instr_rs1 = 5; instr_rs2 = 0;
    expect_instr(ADD, 6, 5, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, 21);
      chk("hold_instr_ready", instr_ready, 0);
    end
    @(posedge clk); #1; res_ready = 1;
    @(posedge clk); #1;
    chk("pending_ready", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 0;
    wait_idle();
    chk("count_bp", instr_count, exp_cnt);

    // Writeback to r0, undefined opcode
    load(1, 32'hF0F0_F0F0); load(2, 32'hFFFF_FFFF);
    issue(AND_, 0, 1, 2);
    issue(ADD, 3, 0, 0);
    @(posedge clk); #1; flag_clr = 1;
    @(posedge clk); #1; flag_clr = 0;
    issue(BAD, 1, 1, 2);
    chk("undef_sticky", {sticky_over, sticky_under}, 0);
    chk("undef_count", instr_count, exp_cnt);
    issue(ADD, 7, 1, 0);
    issue(NOT_, 6, 1, 4);

    // Load in the accept cycle: operands see the old value
    load(5, 2);
    issue(GTE, 2, 5, 5, .ld_en(1), .la(5), .ld(7));
    issue(ADD, 3, 5, 0, .ld_en(1), .la(5), .ld(9));
    issue(EQ, 4, 5, 5);
    issue(ADD, 6, 5, 0);
    issue(LT, 7, 3, 6);
    chk("count_pre_rst", instr_count, exp_cnt);

    // Asynchronous reset during EXEC
    load(1, 10); load(2, 20);
    @(posedge clk); #1;
    instr_valid = 1; instr_op = ADD; instr_rd = 6; instr_rs1 = 1; instr_rs2 = 2;
    @(posedge clk); #1;
    instr_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_res_valid", res_valid, 0);
    chk("arst_idle", instr_ready, 1);
    chk("arst_count", instr_count, 0);
    chk("arst_alu", {alu_sel, alu_a, alu_b}, 0);
    for (int i = 0; i < 8; i++) sh[i] = '0;
    sb.delete();
    exp_cnt = 0;
    @(posedge clk); #1; rst_n = 1;
    issue(ADD, 7, 6, 1);
    chk("count_post_rst", instr_count, 1);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
